// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared load-size encodings, default widths and pipeline-latch control fields
package mem_wb_stage_pkg;
  localparam int DEF_DATA_LENGTH = 32;
  localparam int DEF_ADDR_LENGTH = 5;
  localparam int DEF_CNT_WIDTH   = 32;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b11;
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic       link;
    logic       halt;
    logic       load_unsigned;
    logic [1:0] load_size;
    logic [1:0] byte_off;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-stage payload handed to the MEM/WB latch
// master: MEM stage (drives); slave: mem_wb_stage (samples)
interface mem_wb_stage_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 5
);
  logic                   valid;
  logic                   reg_write;
  logic                   mem_to_reg;
  logic                   link;
  logic                   halt;
  logic [1:0]             load_size;
  logic                   load_unsigned;
  logic [1:0]             byte_off;
  logic [DATA_LENGTH-1:0] alu_result;
  logic [DATA_LENGTH-1:0] mem_rdata;
  logic [DATA_LENGTH-1:0] pc_plus8;
  logic [ADDR_LENGTH-1:0] rd;
  modport master (output valid, reg_write, mem_to_reg, link, halt, load_size, load_unsigned,
                  byte_off, alu_result, mem_rdata, pc_plus8, rd);
  modport slave (input valid, reg_write, mem_to_reg, link, halt, load_size, load_unsigned,
                 byte_off, alu_result, mem_rdata, pc_plus8, rd);
endinterface

// File: rtl/mem_wb_stage_extender.sv
// load_extender: picks the little-endian byte/half lane of a load word and sign/zero-extends it
// in: rdata, size (LS_*), uns (zero-extend), off (address[1:0]); out: data
module load_extender import mem_wb_stage_pkg::*; #(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH
) (
  input  logic [DATA_LENGTH-1:0] rdata,
  input  logic [1:0]             size,
  input  logic                   uns,
  input  logic [1:0]             off,
  output logic [DATA_LENGTH-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];
  assign data = size == LS_BYTE ? {{(DATA_LENGTH-8){~uns & b[7]}}, b} :
                size == LS_HALF ? {{(DATA_LENGTH-16){~uns & h[15]}}, h} : rdata;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, write-back mux, retired counter and sticky HALT
// in: i_clk, i_rst (sync, high), i_enable (advance), i_flush (bubble), m (MEM payload)
// out: o_wb_en/o_wb_reg/o_wb_data (register bank port), o_halt, o_retired
module mem_wb_stage import mem_wb_stage_pkg::*; #(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int ADDR_LENGTH = DEF_ADDR_LENGTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_flush,
  mem_wb_stage_if.slave          m,
  output logic                   o_wb_en,
  output logic [ADDR_LENGTH-1:0] o_wb_reg,
  output logic [DATA_LENGTH-1:0] o_wb_data,
  output logic                   o_halt,
  output logic [CNT_WIDTH-1:0]   o_retired
);
  ctrl_t                  ctrl;
  logic [DATA_LENGTH-1:0] alu_q, rdata_q, pc8_q, ld_data;
  logic [ADDR_LENGTH-1:0] rd_q;
  logic                   halt_seen, blocked, take;
  assign halt_seen = ctrl.valid & ctrl.halt;
  // A HALT sitting in the stage already blocks the next capture, so nothing younger retires
  // in the cycle before o_halt becomes visible.
  assign blocked = o_halt | halt_seen;
  assign take = ~i_flush & ~blocked & i_enable;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl      <= CTRL_BUBBLE;
      alu_q     <= '0;
      rdata_q   <= '0;
      pc8_q     <= '0;
      rd_q      <= '0;
      o_halt    <= 1'b0;
      o_retired <= '0;
    end else begin
      if (i_flush | blocked) begin
        ctrl    <= CTRL_BUBBLE;
        alu_q   <= '0;
        rdata_q <= '0;
        pc8_q   <= '0;
        rd_q    <= '0;
      end else if (i_enable) begin
        ctrl    <= '{valid: m.valid, reg_write: m.reg_write, mem_to_reg: m.mem_to_reg,
                     link: m.link, halt: m.halt, load_unsigned: m.load_unsigned,
                     load_size: m.load_size, byte_off: m.byte_off};
        alu_q   <= m.alu_result;
        rdata_q <= m.mem_rdata;
        pc8_q   <= m.pc_plus8;
        rd_q    <= m.rd;
      end
      if (halt_seen) o_halt <= 1'b1;
      if (take & m.valid & ~&o_retired) o_retired <= o_retired + CNT_WIDTH'(1);
    end
  end
  load_extender #(.DATA_LENGTH(DATA_LENGTH)) u_ext (
    .rdata(rdata_q),
    .size (ctrl.load_size),
    .uns  (ctrl.load_unsigned),
    .off  (ctrl.byte_off),
    .data (ld_data)
  );
  assign o_wb_en   = ctrl.valid & ctrl.reg_write & ~ctrl.halt & (rd_q != '0);
  assign o_wb_reg  = rd_q;
  assign o_wb_data = ctrl.link ? pc8_q : ctrl.mem_to_reg ? ld_data : alu_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table plus stall/flush/halt/reset sequences for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst, enable, flush;
  logic        wb_en, halt_o;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data, retired;
  int          checks = 0;
  int          errors = 0;
  mem_wb_stage_if #(.DATA_LENGTH(32), .ADDR_LENGTH(5)) mif();
  mem_wb_stage dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_enable (enable),
    .i_flush  (flush),
    .m        (mif.slave),
    .o_wb_en  (wb_en),
    .o_wb_reg (wb_reg),
    .o_wb_data(wb_data),
    .o_halt   (halt_o),
    .o_retired(retired)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        valid, rw, m2r, link;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] alu, rdata, pc8;
    logic [4:0]  rd;
    logic        e_en;
    logic [31:0] e_data, e_ret;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic put(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                     input logic h);
    mif.valid = v; mif.reg_write = rw; mif.mem_to_reg = 1'b0; mif.link = 1'b0; mif.halt = h;
    mif.load_size = 2'b11; mif.load_unsigned = 1'b0; mif.byte_off = 2'b00;
    mif.alu_result = alu; mif.mem_rdata = 32'h0; mif.pc_plus8 = 32'h0; mif.rd = rd;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic en, input logic [4:0] r,
                         input logic [31:0] d, input logic h, input logic [31:0] ret);
    chk({tag, ".wb_en"}, 32'(wb_en), 32'(en));
    chk({tag, ".wb_reg"}, 32'(wb_reg), 32'(r));
    chk({tag, ".wb_data"}, wb_data, d);
    chk({tag, ".halt"}, 32'(halt_o), 32'(h));
    chk({tag, ".retired"}, retired, ret);
  endtask
  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 32'h1234ABCD, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234ABCD, 32'd1};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd2, 32'hDEAD0000, 32'h80FF7F01, 32'h0, 5'd1, 1'b1, 32'hFFFFFFFF, 32'd2};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'd3, 32'hDEAD0000, 32'h80FF7F01, 32'h0, 5'd2, 1'b1, 32'h00000080, 32'd3};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'd2, 32'hDEAD0000, 32'h80FF7F01, 32'h0, 5'd3, 1'b1, 32'hFFFF80FF, 32'd4};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 2'd0, 32'hDEAD0000, 32'h80FF7F01, 32'h0, 5'd4, 1'b1, 32'h00007F01, 32'd5};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 2'd1, 32'hDEAD0000, 32'h80FF7F01, 32'h0, 5'd6, 1'b1, 32'h80FF7F01, 32'd6};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 2'd2, 32'hDEAD0000, 32'h80FF7F01, 32'h0, 5'd7, 1'b1, 32'h80FF7F01, 32'd7};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 32'h00000055, 32'h0, 32'h0, 5'd0, 1'b0, 32'h00000055, 32'd8};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 32'h00000099, 32'h80FF7F01, 32'h48, 5'd31, 1'b1, 32'h00000048, 32'd9};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 32'h00000011, 32'h0, 32'h0, 5'd3, 1'b0, 32'h00000011, 32'd9};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'd1, 32'hDEAD0000, 32'h80FF7F01, 32'h0, 5'd8, 1'b1, 32'h0000007F, 32'd10};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'd0, 32'h00000022, 32'h0, 32'h0, 5'd6, 1'b0, 32'h00000022, 32'd11};
    rst = 1'b1; enable = 1'b0; flush = 1'b0;
    put(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    step();
    chk_all("reset", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mif.valid = vecs[i].valid; mif.reg_write = vecs[i].rw; mif.mem_to_reg = vecs[i].m2r;
      mif.link = vecs[i].link; mif.halt = 1'b0; mif.load_size = vecs[i].size;
      mif.load_unsigned = vecs[i].uns; mif.byte_off = vecs[i].off; mif.alu_result = vecs[i].alu;
      mif.mem_rdata = vecs[i].rdata; mif.pc_plus8 = vecs[i].pc8; mif.rd = vecs[i].rd;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].rd, vecs[i].e_data, 1'b0, vecs[i].e_ret);
    end
    put(1'b1, 1'b1, 5'd4, 32'hAAAA5555, 1'b0);
    step();
    chk_all("stall_pre", 1'b1, 5'd4, 32'hAAAA5555, 1'b0, 32'd12);
    enable = 1'b0;
    put(1'b1, 1'b1, 5'd9, 32'h0BADF00D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("stall%0d", i), 1'b1, 5'd4, 32'hAAAA5555, 1'b0, 32'd12);
    end
    flush = 1'b1;
    step();
    chk_all("flush", 1'b0, 5'd0, 32'h0, 1'b0, 32'd12);
    flush = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, 1'b1, 5'(i), 32'(i * 3), 1'b0);
      step();
    end
    chk("pre_halt.retired", retired, 32'd8);
    put(1'b1, 1'b1, 5'd9, 32'h0, 1'b1);
    step();
    chk_all("halt_in", 1'b0, 5'd9, 32'h0, 1'b0, 32'd9);
    put(1'b1, 1'b1, 5'd7, 32'h77777777, 1'b0);
    step();
    chk_all("halt_set", 1'b0, 5'd0, 32'h0, 1'b1, 32'd9);
    step();
    chk_all("halt_hold", 1'b0, 5'd0, 32'h0, 1'b1, 32'd9);
    rst = 1'b1;
    step();
    chk_all("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0;
    put(1'b1, 1'b1, 5'd5, 32'h1234ABCD, 1'b0);
    step();
    chk_all("resume", 1'b1, 5'd5, 32'h1234ABCD, 1'b0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
